alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle controller that sequences the 4-bit operation units (AND, OR, ADD, SUB) of the datapath. It owns a 4-entry x 4-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads the operands, asserts exactly one unit enable for one cycle, captures the unit result and writes it back. Disabled units output 0, so the four unit outputs are OR-combined externally into `alu_result`.

## Interface
- `DATA_W`, default 4: operand/register width. Only 4 is supported.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `instr_valid  in  1`: instruction present.
- `instr_ready  out  1`: high only in IDLE.
- `opcode  in  3`: 000 NOP, 001 LDI, 010 AND, 011 OR, 100 ADD, 101 SUB, 110 MOV, 111 illegal.
- `rd`, `rs1`, `rs2`  in  2 each: destination and source register indices.
- `imm  in  4`: immediate for LDI.
- `en_and`, `en_or`, `en_add`, `en_sub`  out  1 each: one-hot unit enables.
- `Rd1`, `Rd2`  out  4: operand bus to the units.
- `alu_result  in  4`: OR of all unit outputs.
- `done  out  1`: one-cycle pulse when an instruction retires.
- `err  out  1`: one-cycle pulse, coincident with `done`, for an illegal opcode.
- `busy  out  1`: inverse of `instr_ready`.
- `zero  out  1`: sticky flag, set to (written value == 0) by AND/OR/ADD/SUB only.
- `dbg_addr  in  2`, `dbg_data  out  4`: combinational register-file read port.

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch opcode, rd, rs1, rs2 and imm, then go to READ.
- READ: latch `op_a`=reg[rs1] and `op_b`=reg[rs2].
  - AND/OR/ADD/SUB: go to EXEC.
  - LDI: `res_q`=imm, go to WB.
  - MOV: `res_q`=reg[rs1], go to WB.
  - NOP or illegal: go to IDLE and pulse `done` (plus `err` if illegal). No register write.
- EXEC: drive `Rd1`=op_a and `Rd2`=op_b, and assert the single matching enable. At the edge, `res_q`<=alu_result, then go to WB.
- WB: at the edge, reg[rd]<=res_q and pulse `done` in the following cycle. For ALU ops, `zero`<=(res_q==0). Go to IDLE.
- Outside EXEC, all enables are 0 and `Rd1`/`Rd2` are 4'h0.
- Arithmetic belongs to the units. ADD/SUB wrap modulo 16 and the controller ignores any carry.
- rd may equal rs1 or rs2: operands are latched in READ before the write in WB, so the old value is used.
- `dbg_data` shows the written value starting from the cycle after the WB edge.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-EXEC:
  - state=IDLE, all registers=0, `zero`=0, `done`=`err`=0, enables=0, `Rd1`=`Rd2`=0, `instr_ready`=1 in the next cycle.
  - Any in-flight write is discarded.
- Accept edge is t0. Issue interval is one instruction per 4 cycles (ALU ops) or 3 (LDI/MOV).

| Op | READ | EXEC | WB | `done` high | Register updated | Next accept |
|---|---|---|---|---|---|---|
| AND/OR/ADD/SUB | t0→t1 | t1→t2 (enable high that one cycle) | t2→t3 | cycle after t3 | at t3 | t4 at earliest |
| LDI/MOV | t0→t1 | none | t1→t2 | cycle after t2 | at t2 | t3 at earliest |
| NOP/illegal | t0→t1 | none | none | cycle after t1 (with `err` if illegal) | none | t2 at earliest |

- `instr_valid` held high while busy is not accepted and not queued. The same fields are taken at the next IDLE edge.
- `instr_valid` asserted during the `done` cycle is accepted at that cycle's edge (IDLE coincides with `done`).

## Test plan
- Directed scenarios:
  - **LDI then readback.** LDI r1,0xA then LDI r2,0x6. Each gives `done` 2 cycles after accept. Then `dbg_addr`=1 gives 0xA and `dbg_addr`=2 gives 0x6.
  - **AND.** AND r3,r1,r2 with r1=0xA, r2=0x6. In EXEC: `en_and`=1 for exactly one cycle, other enables 0, `Rd1`=0xA, `Rd2`=0x6; bench model returns 0x2. Then r3=0x2, `zero`=0, and `done` 3 cycles after accept.
  - **ADD wrap.** ADD r0,r1,r2 with 0xA+0x6. r0=0x0, `zero`=1, `en_add` is the only enable. A following LDI r0,0x5 leaves `zero`=1.
  - **Illegal opcode.** opcode 111. `done` and `err` both high for one cycle, 1 cycle after accept. All registers unchanged, no enable ever asserted.
  - **Back-to-back.** Hold `instr_valid`=1 with a queue of LDI, AND, NOP. `instr_ready` is low in every non-IDLE cycle, exactly 3 accepts occur, and there are no duplicate executions.
  - **Reset mid-operation.** Reset (`rst_n`=0) during the EXEC of SUB r1,r1,r2. rd is not written, all registers=0, `zero`=0, `instr_ready`=1 in the cycle after the reset edge, and no `done` pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) that drives the external AND/OR/ADD/SUB
// units, owns a 4x4 register file and retires one instruction at a time.
module alu_sequencer #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [1:0]        rd,
    input  logic [1:0]        rs1,
    input  logic [1:0]        rs2,
    input  logic [DATA_W-1:0] imm,
    output logic              en_and,
    output logic              en_or,
    output logic              en_add,
    output logic              en_sub,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              zero,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    logic [1:0]             state_q, state_d;
    logic [2:0]             opcode_q, opcode_d;
    logic [1:0]             rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0]      imm_q, imm_d;
    logic [DATA_W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W-1:0]      res_q, res_d;
    logic [3:0][DATA_W-1:0] regs_q, regs_d;
    logic                   zero_q, zero_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   is_alu;
    logic                   in_exec;

    assign is_alu = (opcode_q == OP_AND) || (opcode_q == OP_OR) ||
                    (opcode_q == OP_ADD) || (opcode_q == OP_SUB);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        regs_d   = regs_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    rd_d     = rd;
                    rs1_d    = rs1;
                    rs2_d    = rs2;
                    imm_d    = imm;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                // Operands are captured before any write-back, so rd==rs uses the old value.
                op_a_d = regs_q[rs1_q];
                op_b_d = regs_q[rs2_q];
                if (is_alu) begin
                    state_d = S_EXEC;
                end else if (opcode_q == OP_LDI) begin
                    res_d   = imm_q;
                    state_d = S_WB;
                end else if (opcode_q == OP_MOV) begin
                    res_d   = regs_q[rs1_q];
                    state_d = S_WB;
                end else begin
                    done_d  = 1'b1;
                    err_d   = (opcode_q == OP_ILL);
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                state_d = S_WB;
            end
            default: begin
                regs_d[rd_q] = res_q;
                if (is_alu) zero_d = (res_q == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= OP_NOP;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            regs_q   <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            regs_q   <= regs_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Units only see operands during EXEC so their OR-combined outputs stay clean.
    assign in_exec     = (state_q == S_EXEC);
    assign en_and      = in_exec && (opcode_q == OP_AND);
    assign en_or       = in_exec && (opcode_q == OP_OR);
    assign en_add      = in_exec && (opcode_q == OP_ADD);
    assign en_sub      = in_exec && (opcode_q == OP_SUB);
    assign Rd1         = in_exec ? op_a_q : '0;
    assign Rd2         = in_exec ? op_b_q : '0;
    assign instr_ready = (state_q == S_IDLE);
    assign busy        = ~instr_ready;
    assign done        = done_q;
    assign err         = err_q;
    assign zero        = zero_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: external unit datapath plus an instruction-level reference model.
module tb_alu_sequencer;

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] opcode = '0;
    logic [1:0] rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
    logic [3:0] imm = '0;
    logic       en_and, en_or, en_add, en_sub;
    logic [3:0] Rd1, Rd2, alu_result, dbg_data;
    logic       done, err, busy, zero;

    int tests = 0;
    int fails = 0;

    logic [3:0] mregs [4];
    logic       mzero;
    instr_t     q[$];

    alu_sequencer #(.DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .en_and(en_and), .en_or(en_or), .en_add(en_add), .en_sub(en_sub),
        .Rd1(Rd1), .Rd2(Rd2), .alu_result(alu_result), .done(done), .err(err),
        .busy(busy), .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Disabled units output 0; results are OR-combined.
    assign alu_result = ({4{en_and}} & (Rd1 & Rd2)) | ({4{en_or}} & (Rd1 | Rd2)) |
                        ({4{en_add}} & (Rd1 + Rd2)) | ({4{en_sub}} & (Rd1 - Rd2));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk($sformatf("%s reg%0d", tag, a), {28'd0, dbg_data}, {28'd0, mregs[a]});
        end
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, mzero});
    endtask

    function automatic int exp_lat(input logic [2:0] op);
        if (op >= 3'd2 && op <= 3'd5) return 4;
        if (op == 3'd1 || op == 3'd6) return 3;
        return 2;
    endfunction

    function automatic logic [3:0] exp_en(input logic [2:0] op);
        case (op)
            3'd2: return 4'b0001;
            3'd3: return 4'b0010;
            3'd4: return 4'b0100;
            3'd5: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_apply(input instr_t i);
        int a, b, r;
        a = int'(mregs[i.rs1]);
        b = int'(mregs[i.rs2]);
        r = -1;
        case (i.op)
            3'd1: r = int'(i.imm);
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = (a + b) % 16;
            3'd5: r = (a - b + 16) % 16;
            3'd6: r = a;
            default: r = -1;
        endcase
        if (r >= 0) mregs[i.rd] = 4'(r);
        if (i.op >= 3'd2 && i.op <= 3'd5) mzero = (r == 0);
    endtask

    task automatic model_reset();
        for (int a = 0; a < 4; a++) mregs[a] = 4'h0;
        mzero = 1'b0;
    endtask

    // Streams q with instr_valid held high; each new instruction is presented in the done cycle.
    task automatic run_queue(input string tag);
        int idx = 0, lat = 0, en_cyc = 0, accepts = 0, budget;
        logic inflight = 1'b0;
        logic [3:0] en_seen = '0, en;
        budget = 10 * q.size() + 20;
        while (idx < q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
            en = {en_sub, en_add, en_or, en_and};
            if (inflight) lat++;
            if (en != 4'b0) begin
                en_cyc++;
                en_seen |= en;
                chk({tag, " Rd1"}, {28'd0, Rd1}, {28'd0, mregs[q[idx].rs1]});
                chk({tag, " Rd2"}, {28'd0, Rd2}, {28'd0, mregs[q[idx].rs2]});
            end else begin
                chk({tag, " idle Rd"}, {24'd0, Rd1, Rd2}, 32'd0);
            end
            if (done) begin
                chk({tag, " done while busy"}, {31'd0, inflight}, 32'd1);
                chk({tag, " latency"}, lat, exp_lat(q[idx].op));
                chk({tag, " err"}, {31'd0, err}, {31'd0, q[idx].op == 3'd7});
                chk({tag, " enable"}, {28'd0, en_seen}, {28'd0, exp_en(q[idx].op)});
                chk({tag, " enable cycles"}, en_cyc, (exp_en(q[idx].op) != 0) ? 1 : 0);
                model_apply(q[idx]);
                check_regs(tag);
                idx++;
                inflight = 1'b0;
            end else begin
                chk({tag, " err without done"}, {31'd0, err}, 32'd0);
            end
            chk({tag, " ready"}, {31'd0, instr_ready}, {31'd0, !inflight});
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, inflight});
            if (idx < q.size()) begin
                opcode = q[idx].op; rd = q[idx].rd; rs1 = q[idx].rs1;
                rs2 = q[idx].rs2; imm = q[idx].imm;
                instr_valid = 1'b1;
            end else begin
                instr_valid = 1'b0;
            end
            if (instr_ready && instr_valid) begin
                inflight = 1'b1;
                lat = 0; en_cyc = 0; en_seen = '0;
                accepts++;
            end
        end
        chk({tag, " finished in budget"}, {31'd0, idx == q.size()}, 32'd1);
        chk({tag, " accepts"}, accepts, q.size());
        repeat (3) begin
            @(negedge clk);
            chk({tag, " no extra done"}, {31'd0, done}, 32'd0);
        end
        q.delete();
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                                  input logic [1:0] s2, input logic [3:0] im);
        instr_t i;
        i.op = op; i.rd = d; i.rs1 = s1; i.rs2 = s2; i.imm = im;
        return i;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset ready", {31'd0, instr_ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done/err", {30'd0, done, err}, 32'd0);
        chk("reset enables", {28'd0, en_sub, en_add, en_or, en_and}, 32'd0);
        check_regs("reset");

        q.push_back(mk(3'd1, 2'd1, 2'd0, 2'd0, 4'hA));
        q.push_back(mk(3'd1, 2'd2, 2'd0, 2'd0, 4'h6));
        run_queue("ldi");

        q.push_back(mk(3'd2, 2'd3, 2'd1, 2'd2, 4'h0));
        run_queue("and");

        q.push_back(mk(3'd4, 2'd0, 2'd1, 2'd2, 4'h0));
        q.push_back(mk(3'd1, 2'd0, 2'd0, 2'd0, 4'h5));
        run_queue("add wrap");

        q.push_back(mk(3'd7, 2'd1, 2'd2, 2'd3, 4'hF));
        run_queue("illegal");

        q.push_back(mk(3'd1, 2'd2, 2'd0, 2'd0, 4'h3));
        q.push_back(mk(3'd2, 2'd3, 2'd1, 2'd2, 4'h0));
        q.push_back(mk(3'd0, 2'd0, 2'd0, 2'd0, 4'h0));
        run_queue("b2b");

        for (int n = 0; n < 40; n++)
            q.push_back(mk(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
                           2'($urandom), 4'($urandom)));
        run_queue("random");

        q.push_back(mk(3'd1, 2'd1, 2'd0, 2'd0, 4'h9));
        q.push_back(mk(3'd1, 2'd2, 2'd0, 2'd0, 4'h4));
        run_queue("pre-reset");

        // SUB r1,r1,r2 interrupted in EXEC.
        @(negedge clk);
        opcode = 3'd5; rd = 2'd1; rs1 = 2'd1; rs2 = 2'd2; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("mid EXEC en_sub", {31'd0, en_sub}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("mid reset ready", {31'd0, instr_ready}, 32'd1);
        chk("mid reset done", {31'd0, done}, 32'd0);
        chk("mid reset enables", {28'd0, en_sub, en_add, en_or, en_and}, 32'd0);
        chk("mid reset Rd", {24'd0, Rd1, Rd2}, 32'd0);
        check_regs("mid reset");
        repeat (4) begin
            @(negedge clk);
            chk("post reset no done", {31'd0, done}, 32'd0);
        end
        check_regs("post reset");

        q.push_back(mk(3'd1, 2'd2, 2'd0, 2'd0, 4'h7));
        q.push_back(mk(3'd6, 2'd3, 2'd2, 2'd0, 4'h0));
        q.push_back(mk(3'd5, 2'd1, 2'd3, 2'd2, 4'h0));
        run_queue("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
